imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader_pkg.sv | 26 ++
 rtl/imem_boot_loader_packer.sv | 61 ++++++
 rtl/imem_boot_loader.sv | 139 +++++++++++++
 tb/tb_imem_boot_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared constants, loader state encoding and helpers for the imem boot loader.
package imem_boot_loader_pkg;

    localparam int unsigned BYTES_PER_WORD   = 4;
    localparam int unsigned INSTRUCTION_SIZE = 32;
    localparam int unsigned IMEM_SIZE        = 1024;

    typedef enum logic [1:0] {
        LOADER_IDLE  = 2'd0,
        LOADER_LOAD  = 2'd1,
        LOADER_DRAIN = 2'd2,
        LOADER_DONE  = 2'd3
    } loader_state_t;

    function automatic logic [INSTRUCTION_SIZE-1:0] be_to_mask(
        input logic [BYTES_PER_WORD-1:0] be
    );
        logic [INSTRUCTION_SIZE-1:0] m;
        m = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            m[8*k +: 8] = {8{be[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/imem_boot_loader_packer.sv
// Packs accepted stream bytes little-endian into words with byte enables.
module imem_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_accept,
    input  logic [7:0]                  i_data,
    input  logic                        i_last,
    output logic                        o_flush,
    output logic                        o_word_valid,
    output logic [INSTRUCTION_SIZE-1:0] o_wdata,
    output logic [BYTES_PER_WORD-1:0]   o_be
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]                  r_lane;
    logic [INSTRUCTION_SIZE-1:0] r_word;
    logic [BYTES_PER_WORD-1:0]   r_be_acc;
    logic                        r_word_valid;
    logic [INSTRUCTION_SIZE-1:0] r_wdata;
    logic [BYTES_PER_WORD-1:0]   r_be;

    logic [INSTRUCTION_SIZE-1:0] w_word_next;
    logic [BYTES_PER_WORD-1:0]   w_be_next;

    assign w_word_next = r_word | ({24'b0, i_data} << {r_lane, 3'b000});
    assign w_be_next   = r_be_acc | (4'b0001 << r_lane);
    assign o_flush     = i_accept && ((r_lane == LAST_LANE) || i_last);

    // Unwritten lanes stay zero because the accumulator clears on every flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane       <= 2'd0;
            r_word       <= '0;
            r_be_acc     <= '0;
            r_word_valid <= 1'b0;
            r_wdata      <= '0;
            r_be         <= '0;
        end else begin
            r_word_valid <= o_flush;
            if (o_flush) begin
                r_wdata  <= w_word_next;
                r_be     <= w_be_next;
                r_word   <= '0;
                r_be_acc <= '0;
                r_lane   <= 2'd0;
            end else if (i_accept) begin
                r_word   <= w_word_next;
                r_be_acc <= w_be_next;
                r_lane   <= r_lane + 2'd1;
            end
        end
    end

    assign o_word_valid = r_word_valid;
    assign o_wdata      = r_wdata;
    assign o_be         = r_be;

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader for the instruction memory; holds the core until loaded.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum of all committed words.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = IMEM_SIZE,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        cpu_hold,
    output logic        done,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0] checksum,
`endif
    output logic        error
);

    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(MEM_SIZE);

    loader_state_t r_state;
    logic [31:0]   r_word_ptr;
    logic          r_s_ready;
    logic [31:0]   r_mem_addr;
    logic          r_cpu_hold;
    logic          r_done;
    logic          r_error;

    logic          w_accept;
    logic          w_overflow;
    logic          w_pack_accept;
    logic          w_flush;
    logic          w_mem_we;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;

    assign w_accept      = s_valid && r_s_ready;
    assign w_overflow    = ({1'b0, r_word_ptr} >= LIMIT);
    assign w_pack_accept = w_accept && (r_state == LOADER_LOAD) && !w_overflow;

    imem_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_accept     (w_pack_accept),
        .i_data       (s_data),
        .i_last       (s_last),
        .o_flush      (w_flush),
        .o_word_valid (w_mem_we),
        .o_wdata      (w_wdata),
        .o_be         (w_be)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= LOADER_IDLE;
            r_word_ptr <= BASE_ADDR;
            r_s_ready  <= 1'b0;
            r_mem_addr <= BASE_ADDR;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_flush) begin
                r_mem_addr <= r_word_ptr;
                r_word_ptr <= r_word_ptr + 32'd4;
            end
            unique case (r_state)
                LOADER_IDLE: begin
                    if (start) begin
                        r_state   <= LOADER_LOAD;
                        r_s_ready <= 1'b1;
                    end
                end
                LOADER_LOAD: begin
                    if (w_accept) begin
                        if (w_overflow) begin
                            r_error <= 1'b1;
                            if (s_last) begin
                                r_state   <= LOADER_DONE;
                                r_s_ready <= 1'b0;
                            end else begin
                                r_state <= LOADER_DRAIN;
                            end
                        end else if (s_last) begin
                            r_state   <= LOADER_DONE;
                            r_s_ready <= 1'b0;
                        end
                    end
                end
                LOADER_DRAIN: begin
                    if (w_accept && s_last) begin
                        r_state   <= LOADER_DONE;
                        r_s_ready <= 1'b0;
                    end
                end
                LOADER_DONE: begin
                    // The final write is on the bus during the first DONE cycle.
                    if (!r_done) begin
                        r_done     <= 1'b1;
                        r_cpu_hold <= r_error;
                    end
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_mem_we) begin
            r_checksum <= r_checksum ^ (w_wdata & be_to_mask(w_be));
        end
    end

    assign checksum = r_checksum;
`endif

    assign s_ready   = r_s_ready;
    assign mem_we    = w_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = w_wdata;
    assign mem_be    = w_be;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (MEM_SIZE=8 to reach overflow quickly).
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        cpu_hold;
    logic        done;
    logic        error;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    imem_boot_loader #(
        .MEM_SIZE  (8),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .cpu_hold  (cpu_hold),
        .done      (done),
`ifdef LOADER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .error     (error)
    );

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_wr_cyc = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  q_be[$];

    logic [7:0] img8 [8] = '{8'h13, 8'h00, 8'h00, 8'h93,
                             8'hB3, 8'h00, 8'h21, 8'h00};
    logic [7:0] img6 [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_wdata);
            q_be.push_back(mem_be);
            last_wr_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h5A;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        q_addr.delete();
        q_data.delete();
        q_be.delete();
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'hA5;
    endtask

    task automatic wait_done(input string tag, input logic chk_lat);
        int n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (done && chk_lat) check({tag, "_lat"}, 32'(cyc - last_wr_cyc), 32'd1);
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        if (i < q_addr.size()) begin
            check({tag, "_addr"}, q_addr[i], a);
            check({tag, "_data"}, q_data[i], d);
            check({tag, "_be"}, 32'(q_be[i]), 32'(be));
        end else begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(s_ready), 32'd0);

        // Full-word image, exactly fills the 8-byte memory
        pulse_start;
        for (int i = 0; i < 8; i++) send(img8[i], i == 7);
        wait_done("full", 1'b1);
        check("full_nwr", 32'(q_addr.size()), 32'd2);
        chk_wr("full_w0", 0, 32'h0, 32'h93000013, 4'hF);
        chk_wr("full_w1", 1, 32'h4, 32'h002100B3, 4'hF);
        check("full_hold", 32'(cpu_hold), 32'd0);
        check("full_error", 32'(error), 32'd0);
        check("full_ready", 32'(s_ready), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check("full_csum", checksum, 32'h932100A0);
`endif

        // Partial tail word
        do_reset(2);
        pulse_start;
        for (int i = 0; i < 6; i++) send(img6[i], i == 5);
        wait_done("tail", 1'b1);
        check("tail_nwr", 32'(q_addr.size()), 32'd2);
        chk_wr("tail_w0", 0, 32'h0, 32'hDDCCBBAA, 4'hF);
        chk_wr("tail_w1", 1, 32'h4, 32'h0000FFEE, 4'h3);
        check("tail_hold", 32'(cpu_hold), 32'd0);

        // Gaps in s_valid and a stray start mid-load
        do_reset(2);
        pulse_start;
        for (int i = 0; i < 8; i++) begin
            send(img8[i], i == 7);
            if (i < 7) gap($urandom_range(0, 2));
            if (i == 3) pulse_start;
        end
        wait_done("gap", 1'b1);
        check("gap_nwr", 32'(q_addr.size()), 32'd2);
        chk_wr("gap_w0", 0, 32'h0, 32'h93000013, 4'hF);
        chk_wr("gap_w1", 1, 32'h4, 32'h002100B3, 4'hF);
        check("gap_error", 32'(error), 32'd0);
        check("gap_hold", 32'(cpu_hold), 32'd0);

        // Overflow: 12 bytes into an 8-byte memory
        do_reset(2);
        pulse_start;
        for (int i = 0; i < 12; i++) send(8'(i + 1), i == 11);
        wait_done("ovf", 1'b0);
        gap(4);
        check("ovf_nwr", 32'(q_addr.size()), 32'd2);
        chk_wr("ovf_w0", 0, 32'h0, 32'h04030201, 4'hF);
        chk_wr("ovf_w1", 1, 32'h4, 32'h08070605, 4'hF);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_hold", 32'(cpu_hold), 32'd1);
        check("ovf_ready", 32'(s_ready), 32'd0);

        // Reset mid-load discards the partial word
        do_reset(2);
        pulse_start;
        for (int i = 0; i < 5; i++) send(8'(8'hF0 + i), 1'b0);
        do_reset(1);
        check("mid_hold", 32'(cpu_hold), 32'd1);
        check("mid_ready", 32'(s_ready), 32'd0);
        pulse_start;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        wait_done("mid", 1'b1);
        check("mid_nwr", 32'(q_addr.size()), 32'd1);
        chk_wr("mid_w0", 0, 32'h0, 32'h44332211, 4'hF);
        check("mid_hold_rel", 32'(cpu_hold), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
